// File: rtl/im_uart_loader.sv
// UART boot loader: receives a framed program image (sync, length, words, XOR checksum)
// and writes it into instruction memory, holding the CPU in reset until the image verifies.
module im_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {
        FrIdle, FrLen0, FrLen1, FrData, FrCsum, FrDone, FrError
    } fr_state_e;

    // ---------------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------------
    logic            rx_meta, rx_sync, rx_prev;
    rx_state_e       rx_state;
    logic [CntW-1:0] rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            byte_valid;
    logic            frame_err;

    // rx_prev trails the synchronised line by one cycle for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RxIdle;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RxStart;
                        rx_cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt == HalfLast) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A line already back high at mid-start-bit was a glitch.
                        rx_state <= rx_sync ? RxIdle : RxData;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt == BitLast) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RxStop;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt == BitLast) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state <= RxIdle;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Frame decoder and IM writer
    // ---------------------------------------------------------------------
    fr_state_e   fr_state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;
    logic [15:0] len_rx;
    logic [15:0] word_idx_inc;
    logic        fr_active;

    assign len_rx       = {rx_shift, len_lo};
    assign word_idx_inc = word_idx + 16'd1;
    assign fr_active    = (fr_state == FrLen0) || (fr_state == FrLen1) ||
                          (fr_state == FrData) || (fr_state == FrCsum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_state  <= FrIdle;
            len_lo    <= '0;
            len       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            csum      <= '0;
            im_we     <= 1'b0;
            im_addr   <= BASE_ADDR;
            im_wdata  <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (frame_err && fr_active) begin
                fr_state <= FrError;
                err      <= 1'b1;
                busy     <= 1'b0;
            end else if (byte_valid) begin
                case (fr_state)
                    FrIdle, FrError: begin
                        // Sync restarts a load; words from a failed attempt get overwritten.
                        if (rx_shift == SyncByte) begin
                            fr_state <= FrLen0;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            csum     <= '0;
                            word_idx <= '0;
                            byte_idx <= '0;
                            im_addr  <= BASE_ADDR;
                        end
                    end
                    FrLen0: begin
                        len_lo   <= rx_shift;
                        csum     <= csum ^ rx_shift;
                        fr_state <= FrLen1;
                    end
                    FrLen1: begin
                        len      <= len_rx;
                        csum     <= csum ^ rx_shift;
                        word_idx <= '0;
                        byte_idx <= '0;
                        if ({16'd0, len_rx} > MAX_WORDS) begin
                            fr_state <= FrError;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                        end else if (len_rx == 16'd0) begin
                            fr_state <= FrCsum;
                        end else begin
                            fr_state <= FrData;
                        end
                    end
                    FrData: begin
                        csum     <= csum ^ rx_shift;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            im_wdata <= {rx_shift, word_buf};
                            word_idx <= word_idx_inc;
                            if (word_idx_inc == len) begin
                                fr_state <= FrCsum;
                            end
                        end else begin
                            word_buf <= {rx_shift, word_buf[23:8]};
                        end
                    end
                    FrCsum: begin
                        busy <= 1'b0;
                        if (rx_shift == csum) begin
                            fr_state  <= FrDone;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            fr_state <= FrError;
                            err      <= 1'b1;
                        end
                    end
                    FrDone: begin
                        // Terminal until reset.
                    end
                    default: fr_state <= FrIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/im_uart_loader.md
Name: im_uart_loader

Overview:
- Boot-time writer for the instruction memory. The CPU datapath only reads instruction memory; this block is the write side.
- Receives a framed program image over a UART line and writes it word-by-word into IM through a single-cycle write port.
- Holds the CPU in reset until the image has loaded and its checksum has verified.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 256, largest accepted word count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial input, idle high, 8N1, LSB first.
- im_we  output  1  IM write strobe, one-cycle pulse.
- im_addr  output  32  IM byte address, word aligned.
- im_wdata  output  32  IM write data.
- cpu_rst_n  output  1  active-low reset for the CPU core; high only after a successful load.
- busy  output  1  a frame is in progress.
- done  output  1  load completed and verified.
- err  output  1  the last frame failed.

Behaviour:
- Reset values (asynchronous, rst_n=0): im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0. RX FSM and frame FSM both go to IDLE.
- RX synchroniser: uart_rx passes through 2 flip-flops before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a 1->0 edge on the synchronised line enters START.
  - START: sample at CLKS_PER_BIT/2. If the line reads 1, it was a glitch: return to IDLE, no byte.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first.
  - STOP: sample the stop bit. If 1, emit internal byte_valid for one cycle. If 0, raise internal frame_err for one cycle.
  - Either way, return to IDLE at mid-stop-bit.
- Frame format: 0xA5 sync, LEN_LO, LEN_HI, then LEN words as 4 bytes each little-endian, then CSUM.
  - CSUM = XOR of every byte after the sync byte, up to and including the last data byte.
- Frame FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - IDLE: 0xA5 -> LEN0 and set busy=1. Any other byte is ignored.
  - LEN0: capture the low byte -> LEN1.
  - LEN1: capture the high byte.
    - LEN > MAX_WORDS -> ERROR.
    - LEN == 0 -> CSUM.
    - Otherwise -> DATA; word index = 0, byte index = 0.
  - DATA: assemble {b3,b2,b1,b0}. The cycle after b3 is received:
    - im_we=1 for exactly that cycle.
    - im_addr = BASE_ADDR + 4*index; im_wdata = the assembled word. Both hold until the next write.
    - index increments. When index reaches LEN -> CSUM.
  - CSUM: match -> DONE, mismatch -> ERROR.
  - DONE: done=1, cpu_rst_n=1, busy=0. All further RX is ignored until rst_n.
  - ERROR: err=1, busy=0, cpu_rst_n=0.
    - A new 0xA5 restarts the load: err=0, index=0, im_addr=BASE_ADDR, next state LEN0.
    - IM words written earlier remain but are overwritten by the retry.
- frame_err in LEN0, LEN1, DATA or CSUM -> ERROR. frame_err in IDLE, ERROR or DONE is ignored.
- Checksum accumulator: cleared on accepting sync; XORs each byte in LEN0, LEN1 and DATA.
- Latency: byte_valid occurs about 9.5 bit times after the start edge, plus 2 synchroniser cycles. im_we rises 1 cycle after the b3 byte_valid.
- Widths: word index is 16 bits. Address arithmetic is 32-bit modulo; no wrap check beyond MAX_WORDS.
- rst_n asserted mid-frame: immediate return to reset values. No partial write is issued.

Test Plan (CLKS_PER_BIT=4, BASE_ADDR=0):
1. Reset: hold rst_n=0 with uart_rx=1 -> all outputs at reset values. After release, 20 idle cycles -> im_we never asserts, cpu_rst_n=0.
2. Send A5 02 00 78 56 34 12 EF BE AD DE 28 -> im_we pulses twice: (addr 0x0, data 0x12345678) then (addr 0x4, data 0xDEADBEEF). After the CSUM byte: done=1, cpu_rst_n=1, busy=0.
3. Same frame with CSUM 0x29 -> err=1, done=0, cpu_rst_n=0. Then resend the frame from test 2 -> err=0 on sync, done=1 at end, same two writes.
4. Stop bit forced to 0 on the 5th byte -> err=1, no further im_we. Glitch of 1 clk low on an idle line -> no byte and no state change. Bytes 0x00 and 0xFF sent in IDLE -> ignored, busy stays 0.
5. A5 00 00 00 -> done=1 with no im_we. A5 01 01 (LEN=257 > 256) -> err=1 immediately after LEN_HI.
6. rst_n pulsed low between the 2nd and 3rd data bytes -> reset values restored, no im_we. The full frame from test 2 then loads correctly.
